// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock programmable FIFO.
// Depth is derived from the address width, so pointers wrap without extra logic.
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  localparam int ADDR_WIDTH_DEF  = 5;
  localparam int PTR_WIDTH_DEF   = ADDR_WIDTH_DEF;
  localparam int COUNT_WIDTH_DEF = ADDR_WIDTH_DEF + 1;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  // One extra bit so the count can represent a completely full array.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array RAM: one write port, one registered read port and one
// combinational read port that shares the read address.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [DATA_WIDTH-1:0] adata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // rst_i clears only the output register; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
  assign adata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty,
// sticky overflow/underflow, synchronous flush and selectable FWFT reads.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 5,
  parameter int AFULL_THRESH  = 28,
  parameter int AEMPTY_THRESH = 4,
  parameter int FWFT          = FWFT_OFF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_en_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    rd_valid_o,
  input  logic                    flush_i,
  input  logic                    clr_err_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    almost_full_o,
  output logic                    almost_empty_o,
  output logic [ADDR_WIDTH:0]     count_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int CW    = cnt_width(ADDR_WIDTH);

  localparam logic [CW-1:0] DEPTH_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_LVL    = CW'(AEMPTY_THRESH);

  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_prog: AFULL_THRESH out of range 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_prog: AEMPTY_THRESH out of range 0..DEPTH-1");
  end
  if (FWFT != FWFT_OFF && FWFT != FWFT_ON) begin : g_bad_mode
    $error("sync_fifo_prog: FWFT must be FWFT_OFF or FWFT_ON");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, full_q, afull_q, aempty_q;
  logic                  rd_valid_q;
  logic                  ovf_q, udf_q;
  logic                  rd_acc, wr_acc, op_en;
  logic [DATA_WIDTH-1:0] mem_rdata, mem_adata;

  assign op_en  = ~rst_i & ~flush_i;
  assign rd_acc = rd_en_i & ~empty_q;
  assign wr_acc = wr_en_i & (~full_q | rd_acc);

  always_comb begin
    count_d = count_q;
    if (wr_acc & ~rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc & ~wr_acc) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      aempty_q   <= 1'b1;
      afull_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else if (flush_i) begin
      // Error history survives a flush so software can still see it.
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      aempty_q   <= 1'b1;
      afull_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == DEPTH_LVL);
      aempty_q   <= (count_d <= AE_LVL);
      afull_q    <= (count_d >= AF_LVL);
      rd_valid_q <= rd_acc;
      ovf_q      <= (wr_en_i & ~wr_acc) | (ovf_q & ~clr_err_i);
      udf_q      <= (rd_en_i & ~rd_acc) | (udf_q & ~clr_err_i);
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (~op_en),
    .we_i    (wr_acc & op_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data_i),
    .re_i    (rd_acc & op_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata),
    .adata_o (mem_adata)
  );

  // In FWFT mode the array is not reset, so the display is forced to 0 while empty.
  assign rd_data_o  = (FWFT == FWFT_ON) ? (empty_q ? '0 : mem_adata) : mem_rdata;
  assign rd_valid_o = (FWFT == FWFT_ON) ? ~empty_q : rd_valid_q;

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a standard-read and an FWFT instance share stimulus
// and are checked every cycle against a queue model, plus literal spot checks.
module tb_sync_fifo_prog;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  localparam int AF = 28;
  localparam int AE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1;
  logic          full0, empty0, af0, ae0, ovf0, udf0;
  logic          full1, empty1, af1, ae1, ovf1, udf1;
  logic [AW:0]   count0, count1;

  sync_fifo_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF),
                   .AEMPTY_THRESH(AE), .FWFT(0)) dut_std (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(rd_data0), .rd_valid_o(rd_valid0), .flush_i(flush), .clr_err_i(clr_err),
    .full_o(full0), .empty_o(empty0), .almost_full_o(af0), .almost_empty_o(ae0),
    .count_o(count0), .overflow_o(ovf0), .underflow_o(udf0));

  sync_fifo_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF),
                   .AEMPTY_THRESH(AE), .FWFT(1)) dut_fwft (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(rd_data1), .rd_valid_o(rd_valid1), .flush_i(flush), .clr_err_i(clr_err),
    .full_o(full1), .empty_o(empty1), .almost_full_o(af1), .almost_empty_o(ae1),
    .count_o(count1), .overflow_o(ovf1), .underflow_o(udf1));

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: queue contents plus the registered-read output and error bits.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rdd = '0;
  logic          m_rdv = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

  always @(posedge clk) begin
    int  n;
    bit  racc, wacc;
    if (rst) begin
      q.delete(); m_rdd = '0; m_rdv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (flush) begin
      q.delete(); m_rdd = '0; m_rdv = 1'b0;
    end else begin
      n    = q.size();
      racc = rd_en && n > 0;
      wacc = wr_en && (n < DEPTH || racc);
      if (racc) begin
        m_rdd = q.pop_front();
        m_rdv = 1'b1;
      end else begin
        m_rdv = 1'b0;
      end
      if (wacc) q.push_back(wr_data);
      m_ovf = (wr_en && !wacc) || (m_ovf && !clr_err);
      m_udf = (rd_en && !racc) || (m_udf && !clr_err);
    end
  end

  always @(negedge clk) begin
    int n;
    logic [5:0] ef;
    if (chk_en) begin
      n  = q.size();
      ef = {n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_udf};
      chk("std_count", 32'(count0), 32'(n));
      chk("std_flags", 32'({full0, empty0, af0, ae0, ovf0, udf0}), 32'(ef));
      chk("std_rd_valid", 32'(rd_valid0), 32'(m_rdv));
      chk("std_rd_data", 32'(rd_data0), 32'(m_rdd));
      chk("fwft_count", 32'(count1), 32'(n));
      chk("fwft_flags", 32'({full1, empty1, af1, ae1, ovf1, udf1}), 32'(ef));
      chk("fwft_rd_valid", 32'(rd_valid1), 32'(n > 0));
      chk("fwft_rd_data", 32'(rd_data1), (n > 0) ? 32'(q[0]) : 32'h0);
    end
  end

  // One clock: drive at the current negedge, return at the next negedge.
  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r,
                     input bit f = 1'b0, input bit c = 1'b0, input bit rs = 1'b0);
    wr_en = w; wr_data = d; rd_en = r; flush = f; clr_err = c; rst = rs;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_count", 32'(count0), 32'd0);
    chk("reset_empty_ae", 32'({empty0, ae0, full0, af0}), 32'b1100);

    // Underflow on an empty read, then cleared
    cyc(0, 8'h00, 1);
    chk("t1_udf", 32'(udf0), 32'd1);
    chk("t1_count_empty", 32'({count0, empty0, ae0, rd_valid0}), 32'({6'd0, 3'b110}));
    cyc(0, 8'h00, 0, 0, 1);
    chk("t1_udf_clr", 32'(udf0), 32'd0);

    // Standard-mode two-word round trip
    cyc(1, 8'h4D, 0);  chk("t2_cnt1", 32'(count0), 32'd1);
    chk("t5_fwft_shows_first", 32'(rd_data1), 32'h4D);
    cyc(1, 8'hFF, 0);  chk("t2_cnt2", 32'(count0), 32'd2);
    cyc(0, 8'h00, 1);  chk("t2_rd1", 32'({rd_valid0, rd_data0}), 32'h14D);
    chk("t2_cnt3", 32'(count0), 32'd1);
    cyc(0, 8'h00, 1);  chk("t2_rd2", 32'({rd_valid0, rd_data0}), 32'h1FF);
    chk("t2_cnt4", 32'(count0), 32'd0);
    cyc(0, 8'h00, 0);  chk("t2_valid_drop", 32'({rd_valid0, rd_data0}), 32'h0FF);

    // Fill to full, overflow, clear
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 8'(8'h4D + i), 0);
      if (i == AF - 2) chk("t3_af_before", 32'(af0), 32'd0);
      if (i == AF - 1) chk("t3_af_at28", 32'(af0), 32'd1);
      if (i == DEPTH - 2) chk("t3_full_before", 32'(full0), 32'd0);
    end
    chk("t3_full", 32'({full0, count0}), 32'({1'b1, 6'd32}));
    cyc(1, 8'h99, 0);
    chk("t3_ovf", 32'({ovf0, count0}), 32'({1'b1, 6'd32}));
    cyc(0, 8'h00, 0, 0, 1);
    chk("t3_ovf_clr", 32'(ovf0), 32'd0);

    // Simultaneous read/write on a full FIFO
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'(8'hC0 + i), 1);
      chk("t4_pop", 32'(rd_data0), 32'(8'h4D + i));
      chk("t4_cnt_ovf", 32'({count0, ovf0}), 32'({6'd32, 1'b0}));
    end

    // Drain everything; wrapped words appear last
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 8'h00, 1);
      chk("t4_drain", 32'(rd_data0), (i < 29) ? 32'(8'h50 + i) : 32'(8'hC0 + i - 29));
      if (count0 == 5) chk("t3_ae_at5", 32'(ae0), 32'd0);
      if (count0 == 4) chk("t3_ae_at4", 32'(ae0), 32'd1);
    end
    chk("t3_empty", 32'(empty0), 32'd1);

    // FWFT display without a read, then pop
    cyc(1, 8'hA5, 0);
    chk("t5_fwft", 32'({rd_valid1, rd_data1}), 32'h1A5);
    cyc(0, 8'h00, 1);
    chk("t5_pop", 32'({empty1, rd_valid1}), 32'b10);

    // Flush with 10 words and Overflow set
    for (int i = 0; i < DEPTH + 1; i++) cyc(1, 8'(8'h10 + i), 0);
    for (int i = 0; i < DEPTH - 10; i++) cyc(0, 8'h00, 1);
    chk("t6_pre", 32'({count0, ovf0}), 32'({6'd10, 1'b1}));
    cyc(1, 8'hEE, 0, 1);
    chk("t6_flush", 32'({count0, empty0, ovf0, rd_valid1}), 32'({6'd0, 3'b110}));
    cyc(1, 8'h77, 0);
    chk("t6_no_stale", 32'({count1, rd_data1}), 32'({6'd1, 8'h77}));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
          $urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 399) == 0);
    end

    // Reset mid-stream
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h30 + i), 1);
    cyc(1, 8'h55, 1, 0, 0, 1);
    chk("t6_rst", 32'({count0, empty0, full0, ae0, af0, ovf0, udf0, rd_valid0}),
        32'({6'd0, 7'b1010000}));
    chk("t6_rst_data", 32'({rd_data0, rd_data1, rd_valid1}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
